// File: rtl/branch_entry_loader_pkg.sv
// Shared definitions for the branch entry loader: sizing, field-mask bit
// positions, request layout, FSM encoding and the slot-compare helper.
// Optional feature macro: BRANCH_LOADER_CLEAR_EN (adds the CLEAR state).
package branch_entry_loader_pkg;

  localparam int THREAD_COUNT      = 8;
  localparam int THREAD_ADDR_WIDTH = 3;
  localparam int BANK_COUNT        = 4;
  localparam int BANK_ADDR_WIDTH   = 2;
  localparam int PC_WIDTH          = 10;
  localparam int COND_WIDTH        = 3;
  localparam int PRED_WIDTH        = 1;
  localparam int PRED_EN_WIDTH     = 1;
  localparam int FIFO_DEPTH        = 4;
  localparam int FIFO_ADDR_WIDTH   = 2;

  // Field-mask bit positions: {BPE,BP,BC,BD,BO}
  localparam int NUM_FIELDS = 5;
  localparam int MASK_BO    = 0;
  localparam int MASK_BD    = 1;
  localparam int MASK_BC    = 2;
  localparam int MASK_BP    = 3;
  localparam int MASK_BPE   = 4;

  // Clear sweep walks bank-major, thread-minor
  localparam int CLR_W = THREAD_ADDR_WIDTH + BANK_ADDR_WIDTH;

  typedef struct packed {
    logic [THREAD_ADDR_WIDTH-1:0] thread;
    logic [BANK_ADDR_WIDTH-1:0]   bank;
    logic [NUM_FIELDS-1:0]        mask;
    logic [PC_WIDTH-1:0]          origin;
    logic [PC_WIDTH-1:0]          destination;
    logic [COND_WIDTH-1:0]        condition;
    logic [PRED_WIDTH-1:0]        prediction;
    logic [PRED_EN_WIDTH-1:0]     prediction_enable;
  } req_t;

  localparam int REQ_W = $bits(req_t);

`ifdef BRANCH_LOADER_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SLOT, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SLOT} state_t;
`endif

  // Slot that precedes thread t in the barrel; issuing there makes the
  // registered wren land exactly in t's write slot.
  function automatic logic [THREAD_ADDR_WIDTH-1:0] prev_thread(
    input logic [THREAD_ADDR_WIDTH-1:0] t
  );
    if (t == '0) return THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
    return t - THREAD_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/branch_entry_loader_fifo.sv
// Small synchronous request FIFO. Pop is applied before push so a
// simultaneous push/pop on a non-full FIFO keeps the count unchanged.
module branch_entry_loader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointers/count/storage: pop first, then push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - (AW+1)'(1);
    end
    if (push && !full) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      count_d         = count_d + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only pointers define validity
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_entry_loader.sv
// Queues branch-memory writes and issues each one in its target thread's
// write slot, one bank/field set per request, in FIFO order.
// Optional feature macro: BRANCH_LOADER_CLEAR_EN adds clear_req and a
// sweep that zeroes every thread/bank entry.
module branch_entry_loader
  import branch_entry_loader_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [THREAD_ADDR_WIDTH-1:0] write_thread,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [THREAD_ADDR_WIDTH-1:0] req_thread,
  input  logic [BANK_ADDR_WIDTH-1:0]   req_bank,
  input  logic [NUM_FIELDS-1:0]        req_mask,
  input  logic [PC_WIDTH-1:0]          req_origin,
  input  logic [PC_WIDTH-1:0]          req_destination,
  input  logic [COND_WIDTH-1:0]        req_condition,
  input  logic [PRED_WIDTH-1:0]        req_prediction,
  input  logic [PRED_EN_WIDTH-1:0]     req_prediction_enable,
`ifdef BRANCH_LOADER_CLEAR_EN
  input  logic                         clear_req,
`endif
  output logic [BANK_COUNT-1:0]        wren_BO,
  output logic [BANK_COUNT-1:0]        wren_BD,
  output logic [BANK_COUNT-1:0]        wren_BC,
  output logic [BANK_COUNT-1:0]        wren_BP,
  output logic [BANK_COUNT-1:0]        wren_BPE,
  output logic [PC_WIDTH-1:0]          write_data_BO,
  output logic [PC_WIDTH-1:0]          write_data_BD,
  output logic [COND_WIDTH-1:0]        write_data_BC,
  output logic [PRED_WIDTH-1:0]        write_data_BP,
  output logic [PRED_EN_WIDTH-1:0]     write_data_BPE,
  output logic                         busy,
  output logic                         done
);

  state_t                               state_q, state_d;
  logic [NUM_FIELDS-1:0][BANK_COUNT-1:0] wren_q, wren_d;
  logic [PC_WIDTH-1:0]                  data_bo_q, data_bo_d;
  logic [PC_WIDTH-1:0]                  data_bd_q, data_bd_d;
  logic [COND_WIDTH-1:0]                data_bc_q, data_bc_d;
  logic [PRED_WIDTH-1:0]                data_bp_q, data_bp_d;
  logic [PRED_EN_WIDTH-1:0]             data_bpe_q, data_bpe_d;
  logic                                 done_q, done_d;

  req_t                                 push_req, head;
  logic                                 push, pop;
  logic                                 fifo_full, fifo_empty;
  logic [FIFO_ADDR_WIDTH:0]             fifo_count;
  logic                                 slot_hit;
  logic                                 take_clear;

`ifdef BRANCH_LOADER_CLEAR_EN
  logic                                 clear_pend_q, clear_pend_d;
  // Extra top bit marks the settle cycle after the last sweep write
  logic [CLR_W:0]                       clear_cnt_q, clear_cnt_d;

  assign req_ready  = !fifo_full && !clear_pend_q && (state_q != ST_CLEAR);
  assign take_clear = (state_q == ST_IDLE) && clear_pend_q && fifo_empty;
  assign busy       = !fifo_empty || (state_q != ST_IDLE) || done_q || clear_pend_q;
`else
  assign req_ready  = !fifo_full;
  assign take_clear = 1'b0;
  assign busy       = !fifo_empty || (state_q != ST_IDLE) || done_q;
`endif

  assign push = req_valid && req_ready;

  assign push_req = '{thread:            req_thread,
                      bank:              req_bank,
                      mask:              req_mask,
                      origin:            req_origin,
                      destination:       req_destination,
                      condition:         req_condition,
                      prediction:        req_prediction,
                      prediction_enable: req_prediction_enable};

  branch_entry_loader_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue one slot early so the registered wren meets the head's own slot
  assign slot_hit = (write_thread == prev_thread(head.thread));

  // Next state, next registered outputs and FIFO pop decision
  always_comb begin
    state_d    = state_q;
    wren_d     = '0;
    data_bo_d  = data_bo_q;
    data_bd_d  = data_bd_q;
    data_bc_d  = data_bc_q;
    data_bp_d  = data_bp_q;
    data_bpe_d = data_bpe_q;
    done_d     = 1'b0;
    pop        = 1'b0;
`ifdef BRANCH_LOADER_CLEAR_EN
    clear_pend_d = clear_pend_q | clear_req;
    clear_cnt_d  = clear_cnt_q;
`endif
    unique case (state_q)
      // IDLE also checks the slot so a fresh head can issue in its first cycle
      ST_IDLE, ST_WAIT_SLOT: begin
        if (take_clear) begin
`ifdef BRANCH_LOADER_CLEAR_EN
          state_d      = ST_CLEAR;
          clear_cnt_d  = '0;
          clear_pend_d = clear_req;
`endif
        end else if (!fifo_empty) begin
          if (slot_hit) begin
            for (int f = 0; f < NUM_FIELDS; f++) wren_d[f][head.bank] = head.mask[f];
            data_bo_d  = head.origin;
            data_bd_d  = head.destination;
            data_bc_d  = head.condition;
            data_bp_d  = head.prediction;
            data_bpe_d = head.prediction_enable;
            done_d     = 1'b1;
            pop        = 1'b1;
            state_d    = (fifo_count > (FIFO_ADDR_WIDTH+1)'(1) || push) ? ST_WAIT_SLOT
                                                                        : ST_IDLE;
          end else begin
            state_d = ST_WAIT_SLOT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef BRANCH_LOADER_CLEAR_EN
      // Any 8 consecutive slots cover every thread, so no alignment wait
      ST_CLEAR: begin
        if (clear_cnt_q[CLR_W]) begin
          state_d = ST_IDLE;
        end else begin
          for (int f = 0; f < NUM_FIELDS; f++)
            wren_d[f][clear_cnt_q[CLR_W-1 -: BANK_ADDR_WIDTH]] = 1'b1;
          data_bo_d   = '0;
          data_bd_d   = '0;
          data_bc_d   = '0;
          data_bp_d   = '0;
          data_bpe_d  = '0;
          done_d      = (clear_cnt_q[CLR_W-1:0] == '1);
          clear_cnt_d = clear_cnt_q + (CLR_W+1)'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wren_q     <= '0;
      data_bo_q  <= '0;
      data_bd_q  <= '0;
      data_bc_q  <= '0;
      data_bp_q  <= '0;
      data_bpe_q <= '0;
      done_q     <= 1'b0;
`ifdef BRANCH_LOADER_CLEAR_EN
      clear_pend_q <= 1'b0;
      clear_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      data_bo_q  <= data_bo_d;
      data_bd_q  <= data_bd_d;
      data_bc_q  <= data_bc_d;
      data_bp_q  <= data_bp_d;
      data_bpe_q <= data_bpe_d;
      done_q     <= done_d;
`ifdef BRANCH_LOADER_CLEAR_EN
      clear_pend_q <= clear_pend_d;
      clear_cnt_q  <= clear_cnt_d;
`endif
    end
  end

  assign wren_BO        = wren_q[MASK_BO];
  assign wren_BD        = wren_q[MASK_BD];
  assign wren_BC        = wren_q[MASK_BC];
  assign wren_BP        = wren_q[MASK_BP];
  assign wren_BPE       = wren_q[MASK_BPE];
  assign write_data_BO  = data_bo_q;
  assign write_data_BD  = data_bd_q;
  assign write_data_BC  = data_bc_q;
  assign write_data_BP  = data_bp_q;
  assign write_data_BPE = data_bpe_q;
  assign done           = done_q;

endmodule

// File: tb/tb_branch_entry_loader.sv
// Directed bench for branch_entry_loader; write_thread advances once per tick.
module tb_branch_entry_loader;
  import branch_entry_loader_pkg::*;

  logic                         clock;
  logic                         reset;
  logic [THREAD_ADDR_WIDTH-1:0] write_thread;
  logic                         req_valid;
  logic                         req_ready;
  logic [THREAD_ADDR_WIDTH-1:0] req_thread;
  logic [BANK_ADDR_WIDTH-1:0]   req_bank;
  logic [NUM_FIELDS-1:0]        req_mask;
  logic [PC_WIDTH-1:0]          req_origin;
  logic [PC_WIDTH-1:0]          req_destination;
  logic [COND_WIDTH-1:0]        req_condition;
  logic [PRED_WIDTH-1:0]        req_prediction;
  logic [PRED_EN_WIDTH-1:0]     req_prediction_enable;
`ifdef BRANCH_LOADER_CLEAR_EN
  logic                         clear_req;
`endif
  logic [BANK_COUNT-1:0]        wren_BO, wren_BD, wren_BC, wren_BP, wren_BPE;
  logic [PC_WIDTH-1:0]          write_data_BO, write_data_BD;
  logic [COND_WIDTH-1:0]        write_data_BC;
  logic [PRED_WIDTH-1:0]        write_data_BP;
  logic [PRED_EN_WIDTH-1:0]     write_data_BPE;
  logic                         busy;
  logic                         done;

  int checks   = 0;
  int failures = 0;

  branch_entry_loader dut (
    .clock                 (clock),
    .reset                 (reset),
    .write_thread          (write_thread),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_thread            (req_thread),
    .req_bank              (req_bank),
    .req_mask              (req_mask),
    .req_origin            (req_origin),
    .req_destination       (req_destination),
    .req_condition         (req_condition),
    .req_prediction        (req_prediction),
    .req_prediction_enable (req_prediction_enable),
`ifdef BRANCH_LOADER_CLEAR_EN
    .clear_req             (clear_req),
`endif
    .wren_BO               (wren_BO),
    .wren_BD               (wren_BD),
    .wren_BC               (wren_BC),
    .wren_BP               (wren_BP),
    .wren_BPE              (wren_BPE),
    .write_data_BO         (write_data_BO),
    .write_data_BD         (write_data_BD),
    .write_data_BC         (write_data_BC),
    .write_data_BP         (write_data_BP),
    .write_data_BPE        (write_data_BPE),
    .busy                  (busy),
    .done                  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
    write_thread = write_thread + 3'd1;
  endtask

  function automatic logic evt();
    return ((wren_BO | wren_BD | wren_BC | wren_BP | wren_BPE) != '0) || done;
  endfunction

  function automatic logic [31:0] all_wren();
    return 32'({wren_BO, wren_BD, wren_BC, wren_BP, wren_BPE});
  endfunction

  task automatic wait_evt(input int budget, input string tag);
    int n;
    n = 0;
    while (!evt() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(evt()), 32'd1);
  endtask

  task automatic drive(input logic [2:0] th, input logic [1:0] bk, input logic [4:0] m,
                       input logic [9:0] o, input logic [9:0] d, input logic [2:0] c,
                       input logic p, input logic pe);
    req_thread            = th;
    req_bank              = bk;
    req_mask              = m;
    req_origin            = o;
    req_destination       = d;
    req_condition         = c;
    req_prediction        = p;
    req_prediction_enable = pe;
  endtask

  initial begin
    reset = 1'b1;
    write_thread = '0;
    req_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_LOADER_CLEAR_EN
    clear_req = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_wren", all_wren(), 32'd0);
    check("rst_data", 32'({write_data_BO, write_data_BD, write_data_BC, write_data_BP,
                           write_data_BPE}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    // 1: single full-mask write, thread 5 bank 2
    write_thread = 3'd0;
    drive(5, 2, 5'b11111, 10'h1A, 10'h2B, 3'd5, 1'b1, 1'b1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_evt(12, "t1");
    check("t1_wt", 32'(write_thread), 32'd5);
    check("t1_wren_BO", 32'(wren_BO), 32'h4);
    check("t1_wren_BD", 32'(wren_BD), 32'h4);
    check("t1_wren_BC", 32'(wren_BC), 32'h4);
    check("t1_wren_BP", 32'(wren_BP), 32'h4);
    check("t1_wren_BPE", 32'(wren_BPE), 32'h4);
    check("t1_data_BO", 32'(write_data_BO), 32'h1A);
    check("t1_data_BD", 32'(write_data_BD), 32'h2B);
    check("t1_data_BC", 32'(write_data_BC), 32'd5);
    check("t1_data_BP", 32'(write_data_BP), 32'd1);
    check("t1_data_BPE", 32'(write_data_BPE), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    tick();
    check("t1_wren_off", all_wren(), 32'd0);
    check("t1_done_off", 32'(done), 32'd0);
    check("t1_hold_BO", 32'(write_data_BO), 32'h1A);
    check("t1_busy_off", 32'(busy), 32'd0);

    // 2: threads 3,4,5 back-to-back issue on consecutive cycles
    write_thread = 3'd5;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'(3 + i), 2'd0, 5'b00001, 10'(10'h100 + i), 10'h0, 3'd0, 1'b0, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    wait_evt(12, "t2");
    for (int i = 0; i < 3; i++) begin
      check("t2_wt", 32'(write_thread), 32'(3 + i));
      check("t2_wren_BO", 32'(wren_BO), 32'h1);
      check("t2_wren_BD", 32'(wren_BD), 32'h0);
      check("t2_data_BO", 32'(write_data_BO), 32'(10'h100 + i));
      check("t2_done", 32'(done), 32'd1);
      tick();
    end
    check("t2_wren_off", all_wren(), 32'd0);

    // 3: thread 0 wraps the compare to THREAD_COUNT-1
    write_thread = 3'd2;
    drive(0, 3, 5'b00010, 10'h0, 10'h3FF, 3'd0, 1'b0, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_evt(12, "t3");
    check("t3_wt", 32'(write_thread), 32'd0);
    check("t3_wren_BD", 32'(wren_BD), 32'h8);
    check("t3_wren_BO", 32'(wren_BO), 32'h0);
    check("t3_data_BD", 32'(write_data_BD), 32'h3FF);
    tick();

    // mask == 0: retired with done but no wren
    write_thread = 3'd4;
    drive(2, 1, 5'b00000, 10'h0, 10'h0, 3'd0, 1'b0, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_evt(12, "t3m");
    check("t3m_wt", 32'(write_thread), 32'd2);
    check("t3m_done", 32'(done), 32'd1);
    check("t3m_wren", all_wren(), 32'd0);
    tick();
    check("t3m_done_off", 32'(done), 32'd0);

    // 4: fill the FIFO, 5th request waits for the first pop
    write_thread = 3'd7;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(7, 1, 5'b00001, 10'(10'h200 + i), 10'h0, 3'd0, 1'b0, 1'b0);
      check("t4_ready_fill", 32'(req_ready), 32'd1);
      tick();
    end
    drive(7, 1, 5'b00001, 10'h204, 10'h0, 3'd0, 1'b0, 1'b0);
    for (int n = 0; n < 10 && wren_BO == '0; n++) begin
      check("t4_ready_full", 32'(req_ready), 32'd0);
      tick();
    end
    check("t4_pop_wren", 32'(wren_BO), 32'h2);
    check("t4_pop_wt", 32'(write_thread), 32'd7);
    check("t4_pop_data", 32'(write_data_BO), 32'h200);
    check("t4_ready_after_pop", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_evt(10, "t4_drain");
      check("t4_drain_data", 32'(write_data_BO), 32'(10'h200 + i));
      check("t4_drain_wt", 32'(write_thread), 32'd7);
      tick();
    end

    // 5: reset with three entries queued discards them
    write_thread = 3'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(6, 0, 5'b11111, 10'(10'h300 + i), 10'h0, 3'd0, 1'b0, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    check("t5_wren", all_wren(), 32'd0);
    for (int n = 0; n < 10; n++) begin
      tick();
      check("t5_quiet", 32'(evt()), 32'd0);
    end

`ifdef BRANCH_LOADER_CLEAR_EN
    // 6: clear behind one queued entry
    begin
      logic [BANK_COUNT-1:0][THREAD_COUNT-1:0] covered;
      int writes, dones, bk;
      covered = '0;
      writes = 0;
      dones = 0;
      write_thread = 3'd0;
      drive(4, 2, 5'b11111, 10'h55, 10'h66, 3'd7, 1'b1, 1'b1);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("t6_ready_pend", 32'(req_ready), 32'd0);
      wait_evt(10, "t6_entry");
      check("t6_entry_wt", 32'(write_thread), 32'd4);
      check("t6_entry_wren", 32'(wren_BO), 32'h4);
      check("t6_entry_data", 32'(write_data_BO), 32'h55);
      check("t6_entry_ready", 32'(req_ready), 32'd0);
      for (int n = 0; n < 45; n++) begin
        tick();
        if (evt()) begin
          bk = 0;
          for (int j = 0; j < BANK_COUNT; j++) if (wren_BO[j]) bk = j;
          writes++;
          check("t6_onehot", 32'($onehot(wren_BO)), 32'd1);
          check("t6_fields", 32'({wren_BD, wren_BC, wren_BP, wren_BPE}),
                32'({wren_BO, wren_BO, wren_BO, wren_BO}));
          check("t6_zero", 32'({write_data_BO, write_data_BD, write_data_BC,
                                write_data_BP, write_data_BPE}), 32'd0);
          check("t6_ready", 32'(req_ready), 32'd0);
          check("t6_dup", 32'(covered[bk][write_thread]), 32'd0);
          covered[bk][write_thread] = 1'b1;
          if (done) begin
            dones++;
            check("t6_done_last", 32'(writes), 32'd32);
          end
        end
      end
      check("t6_writes", 32'(writes), 32'd32);
      check("t6_dones", 32'(dones), 32'd1);
      check("t6_cover", 32'($countones(covered)), 32'd32);
      check("t6_ready_end", 32'(req_ready), 32'd1);
      check("t6_busy_end", 32'(busy), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
